// File: rtl/prm_obstacle_sweeper.sv
// rtl/prm_obstacle_sweeper.sv - streams voxel codes to the edge-check bank and ORs hits into a frame mask
// Optional per-frame obstacle counter enabled by PRM_SWEEP_OBSCNT_EN.
module prm_obstacle_sweeper #(
    parameter int NUM_EDGES = 512,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [14:0]          i_s_code,
    input  logic                 i_s_last,
    output logic [14:0]          o_chk_code,
    output logic                 o_chk_vld,
    input  logic [NUM_EDGES-1:0] i_edge_hit,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [NUM_EDGES-1:0] o_m_mask,
    output logic [CNT_W-1:0]     o_m_obs_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_handshake;
    logic [NUM_EDGES-1:0]   r_acc;
    logic [14:0]            r_chk_code;
    logic                   r_chk_vld;

    // s_ready depends only on state (and reset), never on s_valid.
    always_comb begin
        w_next      = r_state;
        o_s_ready   = 1'b0;
        o_m_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                o_s_ready = !i_rst;
                if (i_s_valid) w_next = i_s_last ? FLUSH : ACCUM;
            end
            ACCUM: begin
                o_s_ready = !i_rst;
                if (i_s_valid && i_s_last) w_next = FLUSH;
            end
            FLUSH: begin
                w_next = OUT;
            end
            OUT: begin
                o_m_valid = 1'b1;
                if (i_m_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept    = i_s_valid && o_s_ready;
    assign w_handshake = (r_state == OUT) && i_m_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chk_code <= '0;
            r_chk_vld  <= 1'b0;
        end else begin
            r_chk_vld <= w_accept;
            if (w_accept) r_chk_code <= i_s_code;
        end
    end

    // The bank result belongs to the code presented this cycle; ignore it otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (w_handshake) begin
            r_acc <= '0;
        end else if (r_chk_vld) begin
            r_acc <= r_acc | i_edge_hit;
        end
    end

`ifdef PRM_SWEEP_OBSCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_handshake) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_m_obs_cnt = r_cnt;
`else
    assign o_m_obs_cnt = '0;
`endif

    assign o_chk_code = r_chk_code;
    assign o_chk_vld  = r_chk_vld;
    assign o_m_mask   = r_acc;

endmodule
